regfile_mp_sb: RTL and testbench

- Parametrised successor to the single-write, two-read integer register bank.
- Configurable data width, register count and read-port count.
- Two write ports: WB0 for ALU/CSR results, WB1 for late load data.
- Per-register busy scoreboard for outstanding loads, plus a hazard output consumed by decode stall logic.
- Sits between decode (reads, issue) and writeback (WB0/WB1).

---
 rtl/regfile_mp_sb.sv | 107 ++++++++++
 tb/tb_regfile_mp_sb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Parametrised integer register bank: NRD combinational read ports, two
//   write ports (WB0 = ALU/CSR results, WB1 = late load data), and a
//   per-register busy scoreboard for outstanding loads with a decode hazard
//   output. Register 0 is hardwired to zero and is never busy.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> same-cycle write-through forwarding to the read ports, and
//                  hazard suppressed for a busy register being written by WB1
//                  in the same cycle
//     undefined -> read ports show array contents only
//
// Ports
//   clk       : clock, all state updates on posedge
//   rst_h     : asynchronous active-high reset (clears registers and busy)
//   rd_addr   : packed read addresses, port k at [k*AW +: AW]
//   rd_en     : read port k is used by the current instruction
//   rd_data   : packed read data, port k at [k*XLEN +: XLEN]
//   wb0_*     : writeback port 0 (wins over WB1 on the same address)
//   wb1_*     : writeback port 1 (load data; clears the busy bit)
//   iss_ld    : load issued this cycle, marks iss_addr busy
//   iss_addr  : load destination register
//   hazard    : some enabled read port targets a busy register
//   busy_cnt  : number of busy registers
module regfile_mp_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_h,
  input  logic [NRD*AW-1:0]          rd_addr,
  input  logic [NRD-1:0]             rd_en,
  output logic [NRD*XLEN-1:0]        rd_data,
  input  logic                       wb0_en,
  input  logic [AW-1:0]              wb0_addr,
  input  logic [XLEN-1:0]            wb0_data,
  input  logic                       wb1_en,
  input  logic [AW-1:0]              wb1_addr,
  input  logic [XLEN-1:0]            wb1_data,
  input  logic                       iss_ld,
  input  logic [AW-1:0]              iss_addr,
  output logic                       hazard,
  output logic [$clog2(NREGS+1)-1:0] busy_cnt
);

  localparam int CW = $clog2(NREGS + 1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             set_hit, clr_hit;
  logic             set_eff, clr_eff;
  logic [AW-1:0]    ra [NRD];

  // Scoreboard next state. Set is applied after clear so a same-cycle
  // issue to the register being returned by WB1 leaves it busy.
  always_comb begin
    set_hit  = iss_ld && (iss_addr != '0);
    clr_hit  = wb1_en && (wb1_addr != '0);
    set_eff  = set_hit && !busy[iss_addr];
    clr_eff  = clr_hit && busy[wb1_addr] && !(set_hit && (iss_addr == wb1_addr));
    busy_nxt = busy;
    if (clr_hit) busy_nxt[wb1_addr] = 1'b0;
    if (set_hit) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      // Register 0 is never written, so it keeps its reset value of zero.
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (wb0_en && (wb0_addr == AW'(i)))      regs[i] <= wb0_data;
        else if (wb1_en && (wb1_addr == AW'(i))) regs[i] <= wb1_data;
      end
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + CW'(set_eff) - CW'(clr_eff);
    end
  end

  // Read ports and hazard detection.
  always_comb begin
    rd_data = '0;
    hazard  = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra[k] = rd_addr[k*AW +: AW];
      rd_data[k*XLEN +: XLEN] = regs[ra[k]];
`ifdef REGFILE_BYPASS_EN
      if (ra[k] != '0) begin
        if (wb0_en && (wb0_addr == ra[k]))      rd_data[k*XLEN +: XLEN] = wb0_data;
        else if (wb1_en && (wb1_addr == ra[k])) rd_data[k*XLEN +: XLEN] = wb1_data;
      end
      if (rd_en[k] && busy[ra[k]] && !(wb1_en && (wb1_addr == ra[k])))
        hazard = 1'b1;
`else
      if (rd_en[k] && busy[ra[k]])
        hazard = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int CW    = 6;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_h = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD-1:0]      rd_en = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wb0_en = 1'b0;
  logic [AW-1:0]       wb0_addr = '0;
  logic [XLEN-1:0]     wb0_data = '0;
  logic                wb1_en = 1'b0;
  logic [AW-1:0]       wb1_addr = '0;
  logic [XLEN-1:0]     wb1_data = '0;
  logic                iss_ld = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic                hazard;
  logic [CW-1:0]       busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst_h(rst_h),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .iss_ld(iss_ld), .iss_addr(iss_addr),
    .hazard(hazard), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs then change away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb0_en = 1'b0; wb1_en = 1'b0; iss_ld = 1'b0; rd_en = '0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d0, d1;
    rst_h = 1'b1;
    tick(); tick();
    rst_h = 1'b0;
    #1;
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      d0 = rd_data[31:0]; d1 = rd_data[63:32];
      n_cmp++; if (d0 !== 32'h0) begin n_err++; $display("FAIL reset_rd0 a=%0d got=%h exp=0", a, d0); end
      n_cmp++; if (d1 !== 32'h0) begin n_err++; $display("FAIL reset_rd1 a=%0d got=%h exp=0", a, d1); end
    end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
    rd_en = 2'b11; #1;
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    rd_en = '0;
  endtask

  task automatic test_write_read();
    rd_addr = {5'd0, 5'd5};
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (rd_data[31:0] !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      n_err++; $display("FAIL wr_same_cycle got=%h exp=%h", rd_data[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    end
    tick();
    wb0_en = 1'b0; #1;
    n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_next_cycle got=%h exp=deadbeef", rd_data[31:0]); end
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1234;
    rd_addr = {5'd0, 5'd0};
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL wr_x0_same got=%h exp=0", rd_data[31:0]); end
    tick();
    wb0_en = 1'b0; #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL wr_x0_rd0 got=%h exp=0", rd_data[31:0]); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL wr_x0_rd1 got=%h exp=0", rd_data[63:32]); end
  endtask

  task automatic test_dual_write();
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h11;
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h22;
    rd_addr = {5'd0, 5'd7};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== (BYP ? 32'h11 : 32'h0)) begin
      n_err++; $display("FAIL dual_same_byp got=%h exp=%h", rd_data[31:0], BYP ? 32'h11 : 32'h0);
    end
    tick();
    wb0_addr = 5'd3; wb0_data = 32'hA;
    wb1_addr = 5'd4; wb1_data = 32'hB;
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'h11) begin n_err++; $display("FAIL dual_prio got=%h exp=11", rd_data[31:0]); end
    tick();
    idle_inputs();
    rd_addr = {5'd4, 5'd3};
    #1;
    n_cmp++; if (rd_data[31:0] !== 32'hA) begin n_err++; $display("FAIL dual_x3 got=%h exp=a", rd_data[31:0]); end
    n_cmp++; if (rd_data[63:32] !== 32'hB) begin n_err++; $display("FAIL dual_x4 got=%h exp=b", rd_data[63:32]); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL dual_busy_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_scoreboard();
    iss_ld = 1'b1; iss_addr = 5'd9;
    tick();
    iss_ld = 1'b0;
    rd_addr = {5'd0, 5'd9}; rd_en = 2'b00;
    #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt_set got=%0d exp=1", busy_cnt); end
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_haz_unqual got=%b exp=0", hazard); end
    rd_en = 2'b01; #1;
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_haz_set got=%b exp=1", hazard); end
    // WB0 to a busy register writes data but must not clear busy.
    wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h77;
    tick();
    wb0_en = 1'b0; #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_wb0_noclr_cnt got=%0d exp=1", busy_cnt); end
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_wb0_noclr_haz got=%b exp=1", hazard); end
    wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h55;
    #1;
    n_cmp++;
    if (hazard !== !BYP) begin n_err++; $display("FAIL sb_haz_wb1_same got=%b exp=%b", hazard, !BYP); end
    tick();
    wb1_en = 1'b0; #1;
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_haz_clr got=%b exp=0", hazard); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL sb_cnt_clr got=%0d exp=0", busy_cnt); end
    n_cmp++; if (rd_data[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_load_data got=%h exp=55", rd_data[31:0]); end
    rd_en = '0;
  endtask

  task automatic test_set_clear_same();
    iss_ld = 1'b1; iss_addr = 5'd9;
    tick();
    iss_ld = 1'b0; #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL scs_cnt_pre got=%0d exp=1", busy_cnt); end
    iss_ld = 1'b1; iss_addr = 5'd9;
    wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h66;
    tick();
    idle_inputs();
    rd_addr = {5'd0, 5'd9}; rd_en = 2'b01;
    #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL scs_cnt got=%0d exp=1", busy_cnt); end
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL scs_haz got=%b exp=1", hazard); end
    n_cmp++; if (rd_data[31:0] !== 32'h66) begin n_err++; $display("FAIL scs_data got=%h exp=66", rd_data[31:0]); end
    iss_ld = 1'b1; iss_addr = 5'd0;
    tick();
    iss_ld = 1'b0;
    rd_addr = {5'd0, 5'd0}; rd_en = 2'b11;
    #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL scs_x0_cnt got=%0d exp=1", busy_cnt); end
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL scs_x0_haz got=%b exp=0", hazard); end
    rd_en = '0;
  endtask

  task automatic test_fill_and_reset();
    for (int i = 1; i < NREGS; i++) begin
      iss_ld = 1'b1; iss_addr = AW'(i);
      tick();
    end
    iss_ld = 1'b0;
    rd_addr = {5'd31, 5'd5}; rd_en = 2'b10;
    #1;
    n_cmp++; if (busy_cnt !== 6'd31) begin n_err++; $display("FAIL fill_cnt got=%0d exp=31", busy_cnt); end
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL fill_haz_rd1 got=%b exp=1", hazard); end
    // Assert reset between clock edges; effect must be immediate.
    @(posedge clk); #2;
    rst_h = 1'b1; #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d exp=0", busy_cnt); end
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL rst_mid_haz got=%b exp=0", hazard); end
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL rst_mid_x5 got=%h exp=0", rd_data[31:0]); end
    rd_addr = {5'd7, 5'd9}; #1;
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_err++; $display("FAIL rst_mid_x9 got=%h exp=0", rd_data[31:0]); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL rst_mid_x7 got=%h exp=0", rd_data[63:32]); end
    tick();
    rst_h = 1'b0; rd_en = '0;
    tick();
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL rst_rel_cnt got=%0d exp=0", busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_set_clear_same();
    test_fill_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
